// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer.
//   state_t          : sequencer FSM state encoding (IDLE, LOAD, PLAY, GAP)
//   HP_W             : width of a half-period command field (clk cycles)
//   DUR_W            : width of a duration command field (ticks)
//   TICK_DIV_DEFAULT : clk cycles per duration tick (1 ms at 50 MHz)
package note_sequencer_pkg;

    localparam int HP_W             = 20;
    localparam int DUR_W            = 16;
    localparam int TICK_DIV_DEFAULT = 50000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/note_sequencer_tone_gen.sv
// Square-wave divider for the speaker tone.
//   clk, rst    : system clock, asynchronous active-high reset
//   clear       : synchronous restart (counter 0, wave 0)
//   enable      : advance the divider this cycle
//   half_period : clk cycles per half-cycle of the wave; 0 holds wave at 0
//   wave        : square-wave output, toggles when the counter wraps
module tone_gen
    import note_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            enable,
    input  logic [HP_W-1:0] half_period,
    output logic            wave
);

    logic [HP_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (enable && (half_period != '0)) begin
            if (cnt == half_period - HP_W'(1)) begin
                cnt  <= '0;
                wave <= ~wave;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Queued note player: commands (half period, duration) are pushed into a
// small FIFO and played one after another as a square wave on speaker.
//   clk, rst        : system clock, asynchronous active-high reset
//   cmd_valid/ready : command handshake; ready is FIFO not-full
//   cmd_half_period : clk cycles per speaker half-cycle, 0 = rest
//   cmd_dur         : note length in ticks of TICK_DIV clk cycles
//   speaker/speaker2: tone output and its copy
//   busy            : playing, in the inter-note gap, or commands queued
//   note_done       : one-cycle pulse at the end of each note
//   LED             : toggles after every note_done
// Build option: define NOTE_GAP_EN to insert GAP_TICKS ticks of silence
// after every note.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_TICKS  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [HP_W-1:0]  cmd_half_period,
    input  logic [DUR_W-1:0] cmd_dur,
    output logic             speaker,
    output logic             speaker2,
    output logic             busy,
    output logic             note_done,
    output logic             LED
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t                state, next_state;
    logic [HP_W+DUR_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  push, pop;
    logic [HP_W-1:0]       head_hp, hp_q;
    logic [DUR_W-1:0]      head_dur, dur_q, dur_cnt;
    logic [TW-1:0]         tick_cnt;
    logic                  tick_last, play_end, wave;

    // Command FIFO; pointers wrap naturally since the depth is a power of two.
    assign cmd_ready           = (count != CW'(FIFO_DEPTH));
    assign push                = cmd_valid && cmd_ready;
    assign {head_hp, head_dur} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cmd_half_period, cmd_dur};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Note parameters are captured while the head is popped in LOAD.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            hp_q  <= head_hp;
            dur_q <= head_dur;
        end
    end

    // Tick prescaler and tick counter run only in PLAY; any other state
    // (including LOAD) holds them at zero so each note starts clean.
    assign tick_last = (tick_cnt == TW'(TICK_DIV - 1));
    assign play_end  = (state == PLAY) && tick_last && (dur_cnt == dur_q - DUR_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            dur_cnt  <= '0;
        end else if (state == PLAY) begin
            if (tick_last) begin
                tick_cnt <= '0;
                dur_cnt  <= dur_cnt + 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end else begin
            tick_cnt <= '0;
            dur_cnt  <= '0;
        end
    end

`ifdef NOTE_GAP_EN
    localparam int GAP_CYC = GAP_TICKS * TICK_DIV;

    logic [31:0] gap_cnt;
    logic        gap_end;

    assign gap_end = (gap_cnt == 32'(GAP_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            gap_cnt <= '0;
        else if (state == GAP)
            gap_cnt <= gap_cnt + 1'b1;
        else
            gap_cnt <= '0;
    end
`else
    // GAP_TICKS has no effect in this build.
    logic unused_gap_cfg;
    assign unused_gap_cfg = ^GAP_TICKS;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // In LOAD the head is still counted in count, so "more queued" is count > 1.
    always_comb begin
        next_state = state;
        note_done  = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0)
                    next_state = LOAD;
            end
            LOAD: begin
                pop = 1'b1;
                if (head_dur == '0) begin
                    note_done  = 1'b1;
`ifdef NOTE_GAP_EN
                    next_state = GAP;
`else
                    next_state = (count > CW'(1)) ? LOAD : IDLE;
`endif
                end else begin
                    next_state = PLAY;
                end
            end
            PLAY: begin
                if (play_end) begin
                    note_done  = 1'b1;
`ifdef NOTE_GAP_EN
                    next_state = GAP;
`else
                    next_state = (count != '0) ? LOAD : IDLE;
`endif
                end
            end
`ifdef NOTE_GAP_EN
            GAP: begin
                if (gap_end)
                    next_state = (count != '0) ? LOAD : IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    tone_gen u_tone (
        .clk         (clk),
        .rst         (rst),
        .clear       (state != PLAY),
        .enable      (state == PLAY),
        .half_period (hp_q),
        .wave        (wave)
    );

    // The divider may have toggled on the final PLAY edge; gating keeps the
    // speaker silent in every state other than PLAY.
    assign speaker  = wave && (state == PLAY);
    assign speaker2 = speaker;
    assign busy     = (state != IDLE) || (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            LED <= 1'b0;
        else if (note_done)
            LED <= ~LED;
    end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;
    import note_sequencer_pkg::*;

    localparam int TD = 4;
    localparam int GT = 2;
    localparam int FD = 4;
`ifdef NOTE_GAP_EN
    localparam int G = GT * TD;
`else
    localparam int G = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [HP_W-1:0]  cmd_half_period;
    logic [DUR_W-1:0] cmd_dur;
    logic             speaker, speaker2, busy, note_done, LED;

    note_sequencer #(
        .TICK_DIV   (TD),
        .FIFO_DEPTH (FD),
        .GAP_TICKS  (GT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_half_period (cmd_half_period),
        .cmd_dur         (cmd_dur),
        .speaker         (speaker),
        .speaker2        (speaker2),
        .busy            (busy),
        .note_done       (note_done),
        .LED             (LED)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen; "cycle k" is the period after edge k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: each accepted note's timeline, derived from the rules
    // "starts (LOAD) one cycle after acceptance, or right after the previous
    // note plus its gap", "plays dur*TICK_DIV cycles".
    typedef struct {
        int acc;
        int load;
        int done;
        int h;
        int dur;
    } note_t;

    note_t notes[$];
    note_t exp_q[$];
    int    last_done = -1000;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_accept(input int n_acc, input int h, input int d);
        note_t n;
        n.acc  = n_acc;
        n.load = (n_acc + 1 > last_done + 1 + G) ? n_acc + 1 : last_done + 1 + G;
        n.done = n.load + d * TD;
        n.h    = h;
        n.dur  = d;
        last_done = n.done;
        notes.push_back(n);
        exp_q.push_back(n);
    endtask

    task automatic model_flush();
        notes.delete();
        exp_q.delete();
        last_done = -1000;
    endtask

    // Monitor: per-cycle output expectations plus the note_done scoreboard.
    always @(negedge clk) begin
        int    e_spk, e_done, e_busy, e_led, occ;
        note_t n;
        if (rst) begin
            chk("rst_speaker",   speaker,   0);
            chk("rst_speaker2",  speaker2,  0);
            chk("rst_busy",      busy,      0);
            chk("rst_led",       LED,       0);
            chk("rst_note_done", note_done, 0);
            chk("rst_ready",     cmd_ready, 1);
        end else begin
            e_spk = 0; e_done = 0; e_busy = 0; e_led = 0; occ = 0;
            foreach (notes[i]) begin
                if (notes[i].load < cyc && cyc <= notes[i].done && notes[i].h != 0)
                    e_spk = ((cyc - notes[i].load - 1) / notes[i].h) % 2;
                if (notes[i].done == cyc)
                    e_done = 1;
                if (notes[i].acc <= cyc && cyc <= notes[i].done + G)
                    e_busy = 1;
                if (notes[i].done + 1 <= cyc)
                    e_led ^= 1;
                if (notes[i].acc <= cyc && cyc < notes[i].load + 1)
                    occ++;
            end
            chk("speaker",   speaker,   e_spk);
            chk("speaker2",  speaker2,  e_spk);
            chk("note_done", note_done, e_done);
            chk("busy",      busy,      e_busy);
            chk("led",       LED,       e_led);
            chk("cmd_ready", cmd_ready, (occ < FD) ? 1 : 0);
            if (note_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_done", 1, 0);
                end else begin
                    n = exp_q.pop_front();
                    chk("sb_done_cycle", cyc, n.done);
                end
            end
        end
    end

    task automatic send(input int h, input int d);
        int waited = 0;
        cmd_half_period = HP_W'(h);
        cmd_dur         = DUR_W'(d);
        cmd_valid       = 1'b1;
        @(negedge clk);
        while (!cmd_ready && waited < 3000) begin
            waited++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        model_accept(cyc, h, d);
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w = 0;
        while (cyc <= last_done + G + 1 && w < 5000) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (cyc <= last_done + G + 1)
            chk("drain_timeout", 0, 1);
    endtask

    initial begin
        cmd_valid       = 1'b0;
        cmd_half_period = '0;
        cmd_dur         = '0;
        rst             = 1'b1;
        #1;
        chk("init_rst_ready", cmd_ready, 1);
        chk("init_rst_busy",  busy,      0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        idle(2);

        // Single note into an idle block.
        send(3, 2);
        drain();
        chk("single_led", LED, 1);

        // Fill the queue behind a long note; the fifth waits for a pop.
        send(2, 10);
        idle(3);
        for (int i = 0; i < 5; i++)
            send($urandom_range(1, 4), $urandom_range(1, 3));
        drain();

        // Rest and zero-duration notes.
        send(0, 3);
        send(1, 0);
        send(2, 1);
        send(1, 0);
        drain();

        // Randomized traffic with random spacing.
        for (int i = 0; i < 30; i++) begin
            send($urandom_range(0, 5), $urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0)
                idle($urandom_range(0, 6));
        end
        drain();

        // Reset mid-note with two commands queued.
        send(1, 8);
        send(2, 1);
        send(3, 1);
        idle(6);
        #1 rst = 1'b1;
        model_flush();
        #1;
        chk("async_rst_speaker", speaker,   0);
        chk("async_rst_busy",    busy,      0);
        chk("async_rst_led",     LED,       0);
        chk("async_rst_ready",   cmd_ready, 1);
        idle(2);
        #1 rst = 1'b0;
        idle(30);

        // First command after reset follows the normal start timing.
        send(3, 2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, giving clk cycles per duration tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving command queue entries (power of two, at least 2).
REQ-003 SHALL have parameter GAP_TICKS, default 10, giving the inter-note silence in ticks.
REQ-004 clk  in  1  single system clock, 50 MHz, all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  note command offered.
REQ-007 cmd_ready  out  1  queue can accept a command.
REQ-008 cmd_half_period  in  20  clk cycles per speaker half-cycle; 0 means rest.
REQ-009 cmd_dur  in  16  note duration in ticks.
REQ-010 speaker  out  1  square-wave tone output.
REQ-011 speaker2  out  1  copy of speaker.
REQ-012 busy  out  1  a note is playing or the queue is non-empty.
REQ-013 note_done  out  1  one-cycle pulse at the end of each note.
REQ-014 LED  out  1  toggles on every note_done.

Function
REQ-015 The command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both high, and pushed into the FIFO.
REQ-016 cmd_ready SHALL equal not-full; a command offered while full SHALL be held off, never dropped or overwritten.
REQ-017 FSM states SHALL be IDLE, LOAD, PLAY, GAP.
- IDLE->LOAD when the FIFO is non-empty.
- LOAD pops the head, latches half_period and dur, clears the tone and tick counters, and drives speaker 0 -> PLAY.
- PLAY->GAP (if NOTE_GAP_EN) or LOAD/IDLE when the duration expires.
REQ-018 A command accepted at edge N into an empty FIFO in IDLE SHALL be in LOAD during cycle N+1 and PLAY from cycle N+2.
REQ-019 PLAY SHALL last exactly dur*TICK_DIV cycles; the tick counter counts 0..TICK_DIV-1 and the tick count increments on wrap.
REQ-020 dur=0 SHALL skip PLAY: LOAD is followed by the note_done pulse and the next state directly.
REQ-021 In PLAY with half_period H>0, the tone counter SHALL count 0..H-1 and toggle speaker on wrap; H=1 toggles every cycle.
REQ-022 H=0 SHALL hold speaker 0 for the whole note.
REQ-023 note_done SHALL pulse high in the last PLAY cycle, or in the LOAD cycle for dur=0.
REQ-024 LED SHALL toggle on the edge after each note_done.
REQ-025 speaker SHALL be 0 in IDLE, LOAD and GAP.
REQ-026 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 busy SHALL be high when the state is not IDLE or the FIFO is non-empty.

Reset
REQ-029 rst high SHALL immediately force the following, independent of clk:
- state IDLE, FIFO empty;
- all counters 0;
- speaker, speaker2, LED, note_done, busy all 0;
- cmd_ready 1.
REQ-030 rst asserted mid-note SHALL abandon the note and flush all queued commands.
REQ-031 After release, the first accepted command SHALL follow the REQ-018 timing.

Configuration
REQ-032 Macro NOTE_GAP_EN defined: after PLAY the FSM SHALL enter GAP for GAP_TICKS*TICK_DIV cycles with speaker 0, then go to LOAD if the FIFO is non-empty, else IDLE.
REQ-033 Macro NOTE_GAP_EN undefined: the GAP state and its counter SHALL be absent, and PLAY SHALL go directly to LOAD or IDLE.

Structure
REQ-034 A shared package SHALL hold:
- the FSM state enum;
- width constants HP_W=20 and DUR_W=16;
- the default TICK_DIV constant.
REQ-035 The square-wave divider SHALL be a sub-module tone_gen (inputs clk, rst, clear, enable, half_period; output wave), instantiated once.
REQ-036 The FIFO SHALL be inline in note_sequencer.

Verification (TICK_DIV=4, GAP_TICKS=2)
REQ-037 Single note: H=3, dur=2 into an idle block -> LOAD at N+1; speaker toggles every 3 cycles for 8 cycles; note_done in the last cycle; LED=1.
REQ-038 Fill: 5 commands offered back-to-back with the FSM stalled in PLAY on a long note -> cmd_ready low after the 4th accept; the 5th is accepted only after the next pop; all 5 play in order.
REQ-039 Rest and zero duration: H=0, dur=3 -> speaker 0 for 12 cycles; dur=0 -> note_done in the LOAD cycle with no PLAY cycles.
REQ-040 Gap: two notes with NOTE_GAP_EN defined -> 8 silent cycles between them. Without the macro -> the second LOAD immediately follows the first note's last PLAY cycle.
REQ-041 Reset mid-note: rst pulsed during PLAY with 2 commands queued -> speaker, busy and LED go 0 asynchronously, cmd_ready 1, no further notes play.
REQ-042 Simultaneous push/pop: a push in the LOAD cycle with FIFO at 2 entries -> occupancy stays 2 and the order is preserved.
